multi_clock_gen: RTL and testbench
==================================

MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

Interface
REQ-001 SHALL have parameter N, default 2: number of output clock channels, 1..16.
REQ-002 SHALL have parameter W, default 8: half-period counter width, 2..16.
REQ-003 SHALL have parameter DEFAULT_HALF, default 10: reset half-period of every channel, in clk cycles.
REQ-004 SHALL have ports, clock and reset first: clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 en  input  N  per-channel run enable, level-sensitive.
REQ-007 load  input  1  one-cycle strobe that writes load_half into channel load_ch.
REQ-008 load_ch  input  4  target channel index for load.
REQ-009 load_half  input  W  new half-period, in clk cycles.
REQ-010 sync  input  1  one-cycle strobe that phase-aligns all channels.
REQ-011 clk_out  output  N  generated clocks, registered.
REQ-012 tick  output  N  one-cycle pulse in the cycle clk_out[i] toggles, registered.
REQ-013 active  output  N  high while channel i is in state RUN.

Function
REQ-014 Each channel SHALL have two states: IDLE and RUN. IDLE->RUN when en[i]=1; RUN->IDLE when en[i]=0.
REQ-015 In IDLE: counter=0, clk_out[i]=0, tick[i]=0, active[i]=0.
REQ-016 In RUN: the counter increments each cycle. When counter==hp-1: clk_out[i] toggles, tick[i]=1 in that same cycle, counter returns to 0.
REQ-017 An effective half-period of 0 SHALL be treated as 1, so the channel toggles every cycle.
REQ-018 First toggle after IDLE->RUN SHALL occur hp cycles after the first cycle in which en[i]=1 is sampled. clk_out starts low, so the first edge is rising.
REQ-019 Output period SHALL be 2*hp clk cycles at 50% duty.
REQ-020 Each channel SHALL hold an active hp register and a pending shadow register.
REQ-021 load with load_ch<N writes the shadow of that channel. load_ch>=N is ignored with no state change.
REQ-022 Channel in IDLE: the shadow is copied to hp on the cycle after load.
REQ-023 Channel in RUN: the shadow is copied to hp only at the next toggle, so no runt half-period occurs.
REQ-024 A second load before that toggle SHALL overwrite the shadow; the last write wins.
REQ-025 sync SHALL clear every RUN channel's counter to 0 and drive its clk_out to 0, with tick=0 that cycle. All RUN channels then resume in phase.
REQ-026 sync SHALL also apply any pending shadow to hp.
REQ-027 sync and load in the same cycle: load writes the shadow first, then sync applies it, so the new hp is used from the resumed phase.
REQ-028 en[i] falling mid-period SHALL enter IDLE next cycle with clk_out forced low. A pending shadow is kept, and applied on the next cycle while in IDLE.
REQ-029 Counter arithmetic SHALL be W-bit unsigned with no wrap. The compare against hp-1 prevents overflow for any hp up to 2^W-1.

Reset
REQ-030 rst=1 at a clk edge: all channels IDLE, counters=0, hp=shadow=DEFAULT_HALF truncated to W bits, clk_out=0, tick=0, active=0.
REQ-031 rst SHALL override en, load and sync in the same cycle.
REQ-032 rst asserted mid-period: the next cycle's outputs are the reset values; the partial period is discarded.

Structure
REQ-033 Package multi_clock_gen_pkg SHALL hold the channel-state encoding (IDLE, RUN) and the default parameter constants.
REQ-034 Per-channel logic SHALL be sub-module clock_gen_chan, instantiated N times by a genvar generate loop.
REQ-035 The top level SHALL only decode load_ch and fan out sync.

Verification (N=2, W=8, DEFAULT_HALF=10)
REQ-036 Release rst, en=2'b01 -> clk_out[0] rises 10 cycles later, period 20, tick[0] each toggle; clk_out[1]=0, active=2'b01.
REQ-037 Channel 0 running, load ch0 half=3 mid-high-phase -> current half-period completes at 10, following half-periods are 3.
REQ-038 Both channels running, hp 10/4, out of phase; pulse sync -> both clk_out=0 next cycle, then ch1 rises after 4 cycles and ch0 after 10.
REQ-039 load ch0 half=0 -> clk_out[0] toggles every cycle; load_ch=5 -> no change observed.
REQ-040 rst asserted at cycle 7 of a half-period, with simultaneous load and sync -> all outputs 0 next cycle, hp returns to 10.
REQ-041 en[0] dropped mid-period with load pending -> clk_out[0]=0 next cycle; on re-enable, the pending half-period is used.

Source files
------------

// File: rtl/multi_clock_gen_pkg.sv
// Shared definitions for the multi-channel programmable clock generator:
// channel state encoding and default parameter values.
package multi_clock_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int DEF_N    = 2;
    localparam int DEF_W    = 8;
    localparam int DEF_HALF = 10;

endpackage

// File: rtl/clock_gen_chan.sv
// One clock channel: half-period counter, active/shadow half-period pair,
// and the IDLE/RUN control that toggles the generated clock.
module clock_gen_chan
    import multi_clock_gen_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_half_i,
    input  logic         sync_i,
    output logic         clk_o,
    output logic         tick_o,
    output logic         active_o
);

    localparam logic [W-1:0] RST_HALF = W'(DEFAULT_HALF);

    // A programmed half-period of zero behaves like one.
    function automatic logic [W-1:0] eff_half(input logic [W-1:0] h);
        return (h == '0) ? {{(W-1){1'b0}}, 1'b1} : h;
    endfunction

    chan_state_e  state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hp_q, hp_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic [W-1:0] hp_m1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hp_q     <= RST_HALF;
            shadow_q <= RST_HALF;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q | load_i;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        hp_m1    = eff_half(hp_q) - 1'b1;

        if (load_i) begin
            shadow_d = load_half_i;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (pend_q) begin
                    hp_d   = shadow_q;
                    pend_d = load_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else if (sync_i) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end else if (cnt_q == hp_m1) begin
                    // Shadow only lands on a toggle so no half-period is cut short.
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                    if (pend_q) begin
                        hp_d   = shadow_q;
                        pend_d = load_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Sync commits the newest half-period, including one loaded this cycle.
        if (sync_i) begin
            hp_d   = load_i ? load_half_i : (pend_q ? shadow_q : hp_q);
            pend_d = 1'b0;
        end
    end

    assign clk_o    = clk_q;
    assign tick_o   = tick_q;
    assign active_o = (state_q == RUN);

endmodule

// File: rtl/multi_clock_gen.sv
// N-channel programmable clock generator: decodes the load target and fans
// the sync strobe out to one clock_gen_chan per channel.
module multi_clock_gen
    import multi_clock_gen_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int W            = DEF_W,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] en,
    input  logic         load,
    input  logic [3:0]   load_ch,
    input  logic [W-1:0] load_half,
    input  logic         sync,
    output logic [N-1:0] clk_out,
    output logic [N-1:0] tick,
    output logic [N-1:0] active
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_chan
            // Indices at or above N never match, so such loads are dropped.
            logic ld_sel;
            assign ld_sel = load && (load_ch == 4'(i));

            clock_gen_chan #(
                .W            (W),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_chan (
                .clk_i       (clk),
                .rst_i       (rst),
                .en_i        (en[i]),
                .load_i      (ld_sel),
                .load_half_i (load_half),
                .sync_i      (sync),
                .clk_o       (clk_out[i]),
                .tick_o      (tick[i]),
                .active_o    (active[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed bench for multi_clock_gen (N=2, W=8, DEFAULT_HALF=10): each record
// holds inputs, a cycle count to hold them, and the outputs expected afterwards.
module tb_multi_clock_gen;

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic       load;
        logic [3:0] ch;
        logic [7:0] half;
        logic       sync;
        int         cyc;
        logic [1:0] e_clk;
        logic [1:0] e_tick;
        logic [1:0] e_act;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic       load;
    logic [3:0] load_ch;
    logic [7:0] load_half;
    logic       sync;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] active;

    int n_checks = 0;
    int n_pass   = 0;
    int step_no  = 0;

    vec_t tbl[20];

    multi_clock_gen #(.N(2), .W(8), .DEFAULT_HALF(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_ch   (load_ch),
        .load_half (load_half),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] e, input logic l,
                                input logic [3:0] c, input logic [7:0] h, input logic s,
                                input int n, input logic [1:0] ec, input logic [1:0] et,
                                input logic [1:0] ea);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.ch = c; v.half = h; v.sync = s;
        v.cyc = n; v.e_clk = ec; v.e_tick = et; v.e_act = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s step %0d: got %b want %b", name, step_no, got, want);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; en = v.en; load = v.load; load_ch = v.ch;
        load_half = v.half; sync = v.sync;
        repeat (v.cyc) @(posedge clk);
        #1;
        step_no++;
        check("clk_out", clk_out, v.e_clk);
        check("tick", tick, v.e_tick);
        check("active", active, v.e_act);
    endtask

    initial begin
        rst = 1'b1; en = 2'b00; load = 1'b0; load_ch = 4'd0; load_half = 8'd0; sync = 1'b0;
        #1;

        // Enable ch0, run, mid-high-phase reload to 3, then half-period 0 and bad index.
        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01);
        tbl[2]  = mk(0, 2'b01, 0, 0, 0, 0, 9, 2'b00, 2'b00, 2'b01);
        tbl[3]  = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01);
        tbl[4]  = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b01);
        tbl[5]  = mk(0, 2'b01, 0, 0, 0, 0, 9, 2'b00, 2'b01, 2'b01);
        tbl[6]  = mk(0, 2'b01, 0, 0, 0, 0, 10, 2'b01, 2'b01, 2'b01);
        tbl[7]  = mk(0, 2'b01, 0, 0, 0, 0, 4, 2'b01, 2'b00, 2'b01);
        tbl[8]  = mk(0, 2'b01, 1, 0, 3, 0, 1, 2'b01, 2'b00, 2'b01);
        tbl[9]  = mk(0, 2'b01, 0, 0, 0, 0, 4, 2'b01, 2'b00, 2'b01);
        tbl[10] = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
        tbl[11] = mk(0, 2'b01, 0, 0, 0, 0, 2, 2'b00, 2'b00, 2'b01);
        tbl[12] = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01);
        tbl[13] = mk(0, 2'b01, 0, 0, 0, 0, 3, 2'b00, 2'b01, 2'b01);
        tbl[14] = mk(0, 2'b01, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01);
        tbl[15] = mk(0, 2'b01, 0, 0, 0, 0, 2, 2'b01, 2'b01, 2'b01);
        tbl[16] = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
        tbl[17] = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01);
        tbl[18] = mk(0, 2'b01, 1, 5, 7, 0, 1, 2'b00, 2'b01, 2'b01);
        tbl[19] = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01);
        for (int i = 0; i < 20; i++) apply(tbl[i]);

        // Two channels (hp 10 / 4) out of phase, then sync, then sync with load.
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b00, 1, 1, 4, 0, 1, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 3, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 5, 2'b10, 2'b10, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 3, 2'b00, 2'b00, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 4, 2'b00, 2'b10, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b11));
        apply(mk(0, 2'b11, 1, 1, 2, 1, 1, 2'b00, 2'b00, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11));
        apply(mk(0, 2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b11));

        // Reset mid-period together with load and sync: hp must return to 10.
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 7, 2'b00, 2'b00, 2'b01));
        apply(mk(1, 2'b01, 1, 0, 3, 1, 1, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 9, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01));

        // Drop enable with a pending load; re-enable uses the new half-period 5.
        apply(mk(0, 2'b01, 0, 0, 0, 0, 3, 2'b01, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 1, 0, 5, 0, 1, 2'b01, 2'b00, 2'b01));
        apply(mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 4, 2'b00, 2'b00, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b01));
        apply(mk(0, 2'b01, 0, 0, 0, 0, 5, 2'b00, 2'b01, 2'b01));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
